// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types and constants for the round-robin lock arbiter.
package rr_lock_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int HCW = 8;
  localparam logic [HCW-1:0] HOLD_SAT = '1;

  // Index width for a requester count; never below one bit.
  function automatic int clog2_fn(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_lock_arbiter_if #(
  parameter int N    = 8,
  parameter int IDXW = rr_lock_arbiter_pkg::clog2_fn(N)
);

  logic [N-1:0]    req;
  logic            done;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid
  );

endinterface

// File: rtl/rr_lock_arbiter_pick.sv
// Combinational rotating-priority search: first set request at or after ptr,
// wrapping around, returned as one-hot, binary index and an any flag.
module rr_pick #(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    pick_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] sel2;
  logic           carry;

  // Upper copy of the request vector supplies the wrapped positions below ptr.
  always_comb begin
    dbl_req = {req_i, req_i};
    masked  = '0;
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dbl_req[i] & ((i >= N) || (i >= int'(ptr_i)));
    end
  end

  // NOTE: blocking assignments inside always_comb model the ripple of the
  // carry through the loop; every output gets a default first so no latch forms.
  always_comb begin
    sel2  = '0;
    carry = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      sel2[i] = masked[i] & ~carry;
      carry   = carry | masked[i];
    end
  end

  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    for (int i = 0; i < N; i++) begin
      pick_o[i] = sel2[i] | sel2[i+N];
    end
    for (int i = 0; i < N; i++) begin
      if (pick_o[i]) idx_o = idx_o | IDXW'(i);
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Registered round-robin arbiter with grant locking, back-to-back handoff
// and an optional hold limit that only bites while others are waiting.
module rr_lock_arbiter
  import rr_lock_arbiter_pkg::*;
#(
  parameter int N       = 8,
  parameter int IDXW    = clog2_fn(N),
  parameter int MAXHOLD = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  rr_lock_arbiter_if.slave      bus
);

  localparam logic [HCW-1:0]  HOLD_LIM = HCW'(MAXHOLD);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic            abort;
  logic            limit_hit;
  logic            release_g;
  logic [IDXW-1:0] ptr_rel;

  logic [N-1:0]    pick_req;
  logic [IDXW-1:0] pick_ptr;
  logic [N-1:0]    pick_oh;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;

  // Release decode for the current owner (only meaningful in ST_GRANT).
  always_comb begin
    abort     = ~bus.req[idx_q];
    limit_hit = (MAXHOLD != 0) && (hold_q == HOLD_LIM) && (|(bus.req & ~gnt_q));
    release_g = bus.done | abort | limit_hit;
    ptr_rel   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  end

  // On release the search starts just past the owner; an aborting owner is
  // removed from contention, a finishing one stays eligible at lowest priority.
  always_comb begin
    pick_req = bus.req;
    pick_ptr = ptr_q;
    if (state_q == ST_GRANT) begin
      pick_ptr = ptr_rel;
      if (abort) pick_req = bus.req & ~gnt_q;
    end
  end

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req_i  (pick_req),
    .ptr_i  (pick_ptr),
    .pick_o (pick_oh),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_any) state_d = ST_GRANT;
      ST_GRANT: if (release_g && !pick_any) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: grant, index, pointer and hold counter.
  always_comb begin
    ptr_d  = ptr_q;
    hold_d = hold_q;
    gnt_d  = gnt_q;
    idx_d  = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d  = pick_oh;
          idx_d  = pick_idx;
          hold_d = HCW'(1);
        end
      end
      ST_GRANT: begin
        if (release_g) begin
          ptr_d = ptr_rel;
          if (pick_any) begin
            gnt_d  = pick_oh;
            idx_d  = pick_idx;
            hold_d = HCW'(1);
          end else begin
            gnt_d = '0;
            idx_d = '0;
          end
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        gnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs come straight from registers; no req-to-gnt combinational path.
  always_comb begin
    bus.gnt       = gnt_q;
    bus.gnt_idx   = idx_q;
    bus.gnt_valid = |gnt_q;
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter: two instances (no hold limit, limit 4)
// share stimulus and are checked every cycle against a behavioural model.
module tb_rr_lock_arbiter;

  localparam int N    = 8;
  localparam int IDXW = 3;

  logic clk;
  logic reset;
  bit   started;
  int   n_cmp;
  int   n_bad;

  rr_lock_arbiter_if #(.N(N), .IDXW(IDXW)) if0 ();
  rr_lock_arbiter_if #(.N(N), .IDXW(IDXW)) if4 ();

  rr_lock_arbiter #(.N(N), .IDXW(IDXW), .MAXHOLD(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  rr_lock_arbiter #(.N(N), .IDXW(IDXW), .MAXHOLD(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_own  [2];   // owner index, -1 when nobody holds the grant
  int m_ptr  [2];
  int m_hold [2];
  int m_lim  [2] = '{0, 4};

  function automatic int search(input logic [N-1:0] r, input int p);
    for (int j = 0; j < N; j++) begin
      if (r[(p + j) % N]) return (p + j) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input int k, input logic [N-1:0] r, input logic d);
    int w;
    logic [N-1:0] rr;
    logic ab, lim;
    if (reset) begin
      m_own[k] = -1; m_ptr[k] = 0; m_hold[k] = 0;
    end else if (m_own[k] < 0) begin
      w = search(r, m_ptr[k]);
      if (w >= 0) begin m_own[k] = w; m_hold[k] = 1; end
    end else begin
      ab  = !r[m_own[k]];
      rr  = r;
      rr[m_own[k]] = 1'b0;
      lim = (m_lim[k] != 0) && (m_hold[k] == m_lim[k]) && (rr != 0);
      if (d || ab || lim) begin
        m_ptr[k] = (m_own[k] + 1) % N;
        w = search(ab ? rr : r, m_ptr[k]);
        if (w >= 0) begin m_own[k] = w; m_hold[k] = 1; end
        else m_own[k] = -1;
      end else if (m_hold[k] < 255) begin
        m_hold[k]++;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, if0.req, if0.done);
    model_step(1, if4.req, if4.done);
  end

  function automatic logic [N-1:0] exp_gnt(input int k);
    return (m_own[k] < 0) ? '0 : N'(1 << m_own[k]);
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      check("m0_gnt",   32'(if0.gnt),       32'(exp_gnt(0)));
      check("m0_valid", 32'(if0.gnt_valid), 32'(m_own[0] >= 0));
      if (m_own[0] >= 0) check("m0_idx", 32'(if0.gnt_idx), 32'(m_own[0]));
      check("m4_gnt",   32'(if4.gnt),       32'(exp_gnt(1)));
      check("m4_valid", 32'(if4.gnt_valid), 32'(m_own[1] >= 0));
      if (m_own[1] >= 0) check("m4_idx", 32'(if4.gnt_idx), 32'(m_own[1]));
    end
  end

  // One clock: drive on the falling edge, return just after the rising edge.
  task automatic tick(input logic [N-1:0] r, input logic d);
    @(negedge clk);
    if0.req = r; if0.done = d;
    if4.req = r; if4.done = d;
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] vec_req  [16] = '{8'hff, 8'hff, 8'hff, 8'h5a, 8'h5a, 8'h42, 8'h00, 8'h81,
                                  8'h81, 8'h81, 8'h7e, 8'h7e, 8'h10, 8'h18, 8'h08, 8'h00};
  logic         vec_done [16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    n_cmp = 0; n_bad = 0; started = 1'b0;
    if0.req = '0; if0.done = 1'b0;
    if4.req = '0; if4.done = 1'b0;
    reset = 1'b1;
    tick(8'h00, 1'b0);
    started = 1'b1;
    tick(8'h00, 1'b0);
    check("rst_gnt",   32'(if0.gnt),       32'h0);
    check("rst_idx",   32'(if0.gnt_idx),   32'h0);
    check("rst_valid", 32'(if0.gnt_valid), 32'h0);
    reset = 1'b0;

    // First grant, one cycle latency.
    tick(8'h00, 1'b0);
    check("idle_gnt", 32'(if0.gnt), 32'h0);
    tick(8'h14, 1'b0);
    check("first_gnt",   32'(if0.gnt),       32'h04);
    check("first_idx",   32'(if0.gnt_idx),   32'd2);
    check("first_valid", 32'(if0.gnt_valid), 32'h1);

    // Back-to-back handoff on done, then owner 4 gone and done.
    tick(8'h14, 1'b1);
    check("handoff_gnt", 32'(if0.gnt),     32'h10);
    check("handoff_idx", 32'(if0.gnt_idx), 32'd4);
    tick(8'h04, 1'b1);
    check("handback_gnt", 32'(if0.gnt), 32'h04);

    // Wrap-around and sole-requester re-grant.
    tick(8'h80, 1'b1);
    check("own7_gnt", 32'(if0.gnt), 32'h80);
    tick(8'h81, 1'b1);
    check("wrap_gnt", 32'(if0.gnt), 32'h01);
    tick(8'h01, 1'b1);
    check("regrant_gnt", 32'(if0.gnt),     32'h01);
    check("regrant_idx", 32'(if0.gnt_idx), 32'd0);

    // Abort handling.
    tick(8'h08, 1'b0);
    check("own3_gnt", 32'(if0.gnt), 32'h08);
    tick(8'h00, 1'b0);
    check("abort_gnt",   32'(if0.gnt),       32'h0);
    check("abort_valid", 32'(if0.gnt_valid), 32'h0);
    tick(8'h08, 1'b0);
    tick(8'h28, 1'b0);
    check("hold3_gnt", 32'(if0.gnt), 32'h08);
    tick(8'h20, 1'b0);
    check("abort_hand_gnt", 32'(if0.gnt), 32'h20);

    // Hold limit: dut4 releases after 4 cycles, dut0 never does.
    tick(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(8'h03, 1'b0);
      check("lim_hold_gnt", 32'(if4.gnt), 32'h01);
    end
    tick(8'h03, 1'b0);
    check("lim_rel_gnt",   32'(if4.gnt), 32'h02);
    check("nolim_hold_gnt", 32'(if0.gnt), 32'h01);
    for (int i = 0; i < 30; i++) tick(8'h01, 1'b0);
    check("sole_hold4_gnt", 32'(if4.gnt), 32'h01);
    check("sole_hold0_gnt", 32'(if0.gnt), 32'h01);

    // Reset mid-grant, then first grant restarts from position 0.
    tick(8'h10, 1'b0);
    tick(8'hff, 1'b0);
    check("pre_rst_gnt", 32'(if0.gnt), 32'h10);
    reset = 1'b1;
    tick(8'hff, 1'b0);
    check("mid_rst_gnt0",  32'(if0.gnt),       32'h0);
    check("mid_rst_gnt4",  32'(if4.gnt),       32'h0);
    check("mid_rst_valid", 32'(if0.gnt_valid), 32'h0);
    reset = 1'b0;
    tick(8'hff, 1'b0);
    check("post_rst_gnt0", 32'(if0.gnt), 32'h01);
    check("post_rst_gnt4", 32'(if4.gnt), 32'h01);

    // Mixed vectors, checked by the per-cycle model comparison.
    for (int i = 0; i < 16; i++) tick(vec_req[i], vec_done[i]);
    for (int i = 0; i < 12; i++) tick(8'hff, 1'b0);

    @(negedge clk);
    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
